// File: rtl/pc_unit.sv
// Program counter with prioritised redirects and a stall-deferred redirect latch.
// Optional target alignment check: define PC_UNIT_ALIGN_CHECK_EN.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             pc_valid,
    output logic             redirect_pending,
    output logic             align_err
);

    // state | meaning
    // BOOT  | first cycle after reset, pc = RESET_VECTOR, not fetchable
    // RUN   | normal sequencing / redirect
    // HOLD  | stalled with a latched redirect waiting for release
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_JMP  = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] lat_tgt_q, lat_tgt_d;
    logic [1:0]       lat_pri_q, lat_pri_d;
    logic [WIDTH-1:0] win_tgt;
    logic [1:0]       win_pri;
    logic             take_hold;

`ifdef PC_UNIT_ALIGN_CHECK_EN
    logic misalign;
    logic align_err_q, align_err_d;
`endif

    assign pc_seq = pc_q + WIDTH'(INC);

    always_comb begin
        win_pri = PRI_NONE;
        win_tgt = pc_q;
        if (exc_req) begin
            win_pri = PRI_EXC;
            win_tgt = EXC_VECTOR;
        end else if (jump_en) begin
            win_pri = PRI_JMP;
            win_tgt = jump_target;
        end else if (branch_en) begin
            win_pri = PRI_BR;
            win_tgt = branch_target;
        end
`ifdef PC_UNIT_ALIGN_CHECK_EN
        // A misaligned jump/branch becomes an exception so it always wins in HOLD too
        misalign = 1'b0;
        if ((win_pri == PRI_JMP || win_pri == PRI_BR) && win_tgt[1:0] != 2'b00) begin
            win_pri  = PRI_EXC;
            win_tgt  = EXC_VECTOR;
            misalign = 1'b1;
        end
`endif
    end

    assign take_hold = (win_pri != PRI_NONE) && (win_pri >= lat_pri_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        lat_tgt_d = lat_tgt_q;
        lat_pri_d = lat_pri_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    pc_d = (win_pri != PRI_NONE) ? win_tgt : pc_seq;
                end else if (win_pri != PRI_NONE) begin
                    lat_tgt_d = win_tgt;
                    lat_pri_d = win_pri;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (take_hold) begin
                        lat_tgt_d = win_tgt;
                        lat_pri_d = win_pri;
                    end
                end else begin
                    pc_d      = take_hold ? win_tgt : lat_tgt_q;
                    lat_tgt_d = '0;
                    lat_pri_d = PRI_NONE;
                    state_d   = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef PC_UNIT_ALIGN_CHECK_EN
    // Substituted targets always win, so every misalign seen outside BOOT is captured
    assign align_err_d = misalign && (state_q != BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) align_err_q <= 1'b0;
        else        align_err_q <= align_err_d;
    end

    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            lat_tgt_q <= '0;
            lat_pri_q <= PRI_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lat_tgt_q <= lat_tgt_d;
            lat_pri_q <= lat_pri_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = (state_q != BOOT);
    assign redirect_pending = (state_q == HOLD);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table with expected-result queue,
// plus async-reset and 16-bit wrap sequences. Honours PC_UNIT_ALIGN_CHECK_EN.
module tb_pc_unit;

`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        exc;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic        e_pend;
        logic        e_aln;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, exc_req = 1'b0, jump_en = 1'b0, branch_en = 1'b0;
    logic [31:0] jump_target = '0, branch_target = '0;
    logic [31:0] pc, pc_seq;
    logic        pc_valid, redirect_pending, align_err;

    logic        rst16_n = 1'b0;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = '0;
    logic [15:0] pc16, pc_seq16;
    logic        valid16, pend16, aln16;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .exc_req(exc_req),
        .jump_en(jump_en), .jump_target(jump_target),
        .branch_en(branch_en), .branch_target(branch_target),
        .pc(pc), .pc_seq(pc_seq), .pc_valid(pc_valid),
        .redirect_pending(redirect_pending), .align_err(align_err)
    );

    pc_unit #(.WIDTH(16), .RESET_VECTOR(16'hFFF8), .EXC_VECTOR(16'h0180)) dut16 (
        .clk(clk), .rst_n(rst16_n), .stall(zero1), .exc_req(zero1),
        .jump_en(zero1), .jump_target(zero16),
        .branch_en(zero1), .branch_target(zero16),
        .pc(pc16), .pc_seq(pc_seq16), .pc_valid(valid16),
        .redirect_pending(pend16), .align_err(aln16)
    );

    function automatic vec_t v(input logic s, input logic e, input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt, input logic [31:0] p,
                               input logic pend, input logic aln);
        vec_t r;
        r.stall = s; r.exc = e; r.jmp = j; r.jt = jt; r.br = b; r.bt = bt;
        r.e_pc = p; r.e_pend = pend; r.e_aln = aln;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one vector, checks after the next posedge, returns at negedge.
    task automatic step(input vec_t x);
        vec_t e;
        stall = x.stall; exc_req = x.exc; jump_en = x.jmp; jump_target = x.jt;
        branch_en = x.br; branch_target = x.bt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", pc, e.e_pc);
        check("pc_seq", pc_seq, e.e_pc + 32'd4);
        check("pc_valid", {31'd0, pc_valid}, 32'd1);
        check("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.e_pend});
        check("align_err", {31'd0, align_err}, {31'd0, e.e_aln});
        @(negedge clk);
    endtask

    initial begin
        // release from reset; first vector also shows redirects ignored in BOOT
        vecs.push_back(v(0,0,1,32'h500,0,0, 32'h0,   0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h4,   0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h8,   0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'hC,   0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h10,  0,0));
        vecs.push_back(v(0,0,1,32'h200,1,32'h300, 32'h200, 0,0));
        vecs.push_back(v(1,0,0,0,0,0,       32'h200, 0,0));
        // branch latched during 3-cycle stall
        vecs.push_back(v(1,0,0,0,1,32'h40,  32'h200, 1,0));
        vecs.push_back(v(1,0,0,0,0,0,       32'h200, 1,0));
        vecs.push_back(v(1,0,0,0,0,0,       32'h200, 1,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h40,  0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h44,  0,0));
        // latched exception not displaced by jump
        vecs.push_back(v(1,1,0,0,0,0,       32'h44,  1,0));
        vecs.push_back(v(1,0,1,32'h80,0,0,  32'h44,  1,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h180, 0,0));
        // jump replaces latched branch, later branch does not
        vecs.push_back(v(1,0,0,0,1,32'h60,  32'h180, 1,0));
        vecs.push_back(v(1,0,1,32'h70,0,0,  32'h180, 1,0));
        vecs.push_back(v(1,0,0,0,1,32'h90,  32'h180, 1,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h70,  0,0));
        // release with a higher-priority redirect present
        vecs.push_back(v(1,0,0,0,1,32'h60,  32'h70,  1,0));
        vecs.push_back(v(0,0,1,32'h74,0,0,  32'h74,  0,0));
        // release with a lower-priority redirect present
        vecs.push_back(v(1,0,1,32'h64,0,0,  32'h74,  1,0));
        vecs.push_back(v(0,0,0,0,1,32'h98,  32'h64,  0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h68,  0,0));
        // misaligned targets
        vecs.push_back(v(0,0,1,32'h102,0,0, ALN ? 32'h180 : 32'h102, 0, ALN));
        vecs.push_back(v(0,0,0,0,0,0,       ALN ? 32'h184 : 32'h106, 0, 0));
        vecs.push_back(v(1,0,0,0,1,32'h0E,  ALN ? 32'h184 : 32'h106, 1, ALN));
        vecs.push_back(v(0,0,0,0,0,0,       ALN ? 32'h180 : 32'h0E,  0, 0));
        // 32-bit wrap
        vecs.push_back(v(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h0,   0,0));
        vecs.push_back(v(0,0,0,0,0,0,       32'h4,   0,0));
        vecs.push_back(v(1,0,0,0,1,32'h40,  32'h4,   1,0));

        repeat (3) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset pc_seq", pc_seq, 32'h4);
        check("reset pc_valid", {31'd0, pc_valid}, 32'd0);
        check("reset pending", {31'd0, redirect_pending}, 32'd0);
        check("reset align_err", {31'd0, align_err}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // async reset mid-HOLD, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("async pc", pc, 32'h0);
        check("async pc_valid", {31'd0, pc_valid}, 32'd0);
        check("async pending", {31'd0, redirect_pending}, 32'd0);
        check("async align_err", {31'd0, align_err}, 32'd0);
        @(negedge clk);
        stall = 1'b0; branch_en = 1'b0;
        rst_n = 1'b1;
        step(v(0,0,0,0,0,0, 32'h0, 0,0));
        step(v(0,0,0,0,0,0, 32'h4, 0,0));
        step(v(0,0,0,0,0,0, 32'h8, 0,0));

        // 16-bit wrap
        rst16_n = 1'b1;
        @(posedge clk); #1;
        check("w16 boot pc", {16'd0, pc16}, 32'h0000_FFF8);
        check("w16 valid", {31'd0, valid16}, 32'd1);
        @(posedge clk); #1;
        check("w16 pc", {16'd0, pc16}, 32'h0000_FFFC);
        check("w16 pc_seq", {16'd0, pc_seq16}, 32'h0000_0000);
        @(posedge clk); #1;
        check("w16 wrap pc", {16'd0, pc16}, 32'h0000_0000);
        check("w16 align_err", {31'd0, aln16}, 32'd0);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
